full_adder: RTL and testbench



---
 rtl/fa_cell.sv | 17 +
 rtl/full_adder.sv | 60 ++++++
 tb/tb_full_adder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fa_cell.sv
// fa_cell: 1-bit full adder, the leaf cell of the ripple chain.
// Ports: a, b, cin in; sum, cout out.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple adder, {cout,sum} = a + b + cin.
// Ports: clk, rst (sync, high; REG_OUT=1 only), a, b, cin in; sum, cout out.
module full_adder #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum_d[i]),
      .cout(carry[i+1])
    );
  end

  assign cout_d = carry[WIDTH];

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // rst wins over the data sampled on the same edge
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
  end else begin : g_comb
    // clk/rst have no function here; tie them off
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign sum  = sum_d;
    assign cout = cout_d;
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: checks full_adder in several WIDTH/REG_OUT builds
// against a + b + cin computed with plain arithmetic.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // WIDTH=1 combinational
  logic a1, b1, c1, s1, co1;
  full_adder #(.WIDTH(1), .REG_OUT(0)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .cout(co1)
  );

  // WIDTH=4, both flavours, shared inputs
  logic [3:0] a4, b4, s4c, s4r;
  logic       c4, co4c, co4r;
  full_adder #(.WIDTH(4), .REG_OUT(0)) u_w4c (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(c4),
    .sum(s4c), .cout(co4c)
  );
  full_adder #(.WIDTH(4), .REG_OUT(1)) u_w4r (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(c4),
    .sum(s4r), .cout(co4r)
  );

  // WIDTH=8, both flavours, shared inputs
  logic [7:0] a8, b8, s8c, s8r;
  logic       c8, co8c, co8r;
  full_adder #(.WIDTH(8), .REG_OUT(0)) u_w8c (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8),
    .sum(s8c), .cout(co8c)
  );
  full_adder #(.WIDTH(8), .REG_OUT(1)) u_w8r (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8),
    .sum(s8r), .cout(co8r)
  );

  int n_edges = 0;
  always @(s1 or co1) n_edges++;

  task automatic test_reset();
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({co4r, s4r} !== 5'h00) begin
      n_fail++;
      $display("FAIL reset_w4 got %h want 00", {co4r, s4r});
    end
    n_checks++;
    if ({co8r, s8r} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_w8 got %h want 000", {co8r, s8r});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({co4r, s4r} !== 5'h00) begin
      n_fail++;
      $display("FAIL reset_hold got %h want 00", {co4r, s4r});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({co4r, s4r} !== 5'h1F) begin
      n_fail++;
      $display("FAIL reset_release got %h want 1f", {co4r, s4r});
    end
  endtask

  task automatic test_truth_table();
    logic [2:0] v;
    logic [1:0] exp;
    for (int i = 1; i <= 8; i++) begin
      v = 3'(i % 8);
      {a1, b1, c1} = v;
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      #10;
      n_checks++;
      if ({co1, s1} !== exp) begin
        n_fail++;
        $display("FAIL truth_%0d%0d%0d got %b want %b",
                 v[2], v[1], v[0], {co1, s1}, exp);
      end
    end
  endtask

  task automatic test_hold();
    {a1, b1, c1} = 3'b100;
    #10;
    n_edges = 0;
    {a1, b1, c1} = 3'b100;
    #10;
    n_checks++;
    if (n_edges != 0 || {co1, s1} !== 2'b01) begin
      n_fail++;
      $display("FAIL hold got %b edges=%0d want 01 edges=0",
               {co1, s1}, n_edges);
    end
  endtask

  task automatic test_w4_comb();
    logic [12:0] vec [3];
    logic [4:0]  exp;
    vec[0] = {4'hF, 4'h1, 1'b0};
    vec[1] = {4'hF, 4'hF, 1'b1};
    vec[2] = {4'h5, 4'h3, 1'b1};
    for (int i = 0; i < 3; i++) begin
      {a4, b4, c4} = vec[i];
      exp = 5'(a4) + 5'(b4) + 5'(c4);
      #10;
      n_checks++;
      if ({co4c, s4c} !== exp) begin
        n_fail++;
        $display("FAIL w4_comb_%0d got %h want %h",
                 i, {co4c, s4c}, exp);
      end
    end
  endtask

  task automatic test_w4_latency();
    @(negedge clk);
    a4 = 4'h1; b4 = 4'h1; c4 = 1'b0;
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h8; c4 = 1'b1;
    #1;
    n_checks++;
    if ({co4r, s4r} !== 5'h02) begin
      n_fail++;
      $display("FAIL latency_before got %h want 02", {co4r, s4r});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({co4r, s4r} !== 5'h10) begin
      n_fail++;
      $display("FAIL latency_after got %h want 10", {co4r, s4r});
    end
  endtask

  task automatic test_random();
    logic [8:0] exp;
    logic [8:0] pend [$];
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (pend.size() > 0) begin
        exp = pend.pop_front();
        n_checks++;
        if ({co8r, s8r} !== exp) begin
          n_fail++;
          $display("FAIL rand_reg_%0d got %h want %h",
                   i, {co8r, s8r}, exp);
        end
      end
      if (i == 1000) break;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      exp = 9'(a8) + 9'(b8) + 9'(c8);
      pend.push_back(exp);
      #1;
      n_checks++;
      if ({co8c, s8c} !== exp) begin
        n_fail++;
        $display("FAIL rand_comb_%0d got %h want %h",
                 i, {co8c, s8c}, exp);
      end
    end
  endtask

  initial begin
    a1 = 0; b1 = 0; c1 = 0;
    a4 = 0; b4 = 0; c4 = 0;
    a8 = 0; b8 = 0; c8 = 0;
    test_reset();
    test_truth_table();
    test_hold();
    test_w4_comb();
    test_w4_latency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
